// File: rtl/axi_hdr_arb_pkg.sv
// Shared types and constants for the AXI-Stream header arbiter.
//   state_e    : arbiter FSM states (IDLE, HDR, PAY), 2-bit encoding
//   PKT_CNT_WD : width of the completed-packet counter
package axi_hdr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_e;

  localparam int PKT_CNT_WD = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: returns the first set request at or after ptr,
// searching ptr, ptr+1, ... modulo NUM_CH.
//   req     : per-channel request vector
//   ptr     : channel with highest priority this cycle
//   gnt_idx : index of the selected channel (0 when no request)
//   any_req : high when at least one request is set
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_WD  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_WD-1:0]  ptr,
  output logic [CH_WD-1:0]  gnt_idx,
  output logic              any_req
);

  int unsigned idx;

  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(ptr) + i) % 32'(NUM_CH);
      if (!any_req && req[CH_WD'(idx)]) begin
        any_req = 1'b1;
        gnt_idx = CH_WD'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_stream_header_arbiter.sv
// Shares one header-insertion engine among NUM_CH requesters. A channel is
// granted round-robin on its header valid; its header is forwarded, then its
// payload through the last beat, after which the arbiter returns to IDLE for
// one turnaround cycle.
//   s_*_insert    : per-channel header streams (packed, channel i at slice i)
//   s_*_in        : per-channel payload streams (packed)
//   m_*_insert    : header port toward the engine
//   m_*_in        : data port toward the engine
//   grant_id      : currently granted channel, stable for a whole packet
//   busy          : high while in HDR or PAY
//   pkt_cnt       : completed packets, wrapping
module axi_stream_header_arbiter
  import axi_hdr_arb_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_CH       = 4,
  parameter int CH_WD        = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              s_valid_insert,
  input  logic [NUM_CH*DATA_WD-1:0]      s_header_insert,
  input  logic [NUM_CH*DATA_BYTE_WD-1:0] s_keep_insert,
  output logic [NUM_CH-1:0]              s_ready_insert,
  input  logic [NUM_CH-1:0]              s_valid_in,
  input  logic [NUM_CH*DATA_WD-1:0]      s_data_in,
  input  logic [NUM_CH*DATA_BYTE_WD-1:0] s_keep_in,
  input  logic [NUM_CH-1:0]              s_last_in,
  output logic [NUM_CH-1:0]              s_ready_in,
  output logic                           m_valid_insert,
  output logic [DATA_WD-1:0]             m_header_insert,
  output logic [DATA_BYTE_WD-1:0]        m_keep_insert,
  input  logic                           m_ready_insert,
  output logic                           m_valid_in,
  output logic [DATA_WD-1:0]             m_data_in,
  output logic [DATA_BYTE_WD-1:0]        m_keep_in,
  output logic                           m_last_in,
  input  logic                           m_ready_in,
  output logic [CH_WD-1:0]               grant_id,
  output logic                           busy,
  output logic [PKT_CNT_WD-1:0]          pkt_cnt
);

  state_e           state;
  logic [CH_WD-1:0] rr_ptr;
  logic [CH_WD-1:0] arb_idx;
  logic             arb_any;
  logic             sel_valid_insert;
  logic             sel_valid_in;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_WD  (CH_WD)
  ) u_rr_arbiter (
    .req     (s_valid_insert),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  // Source mux: always driven from grant_id so the buses never float to X.
  always_comb begin
    sel_valid_insert = 1'b0;
    sel_valid_in     = 1'b0;
    m_header_insert  = '0;
    m_keep_insert    = '0;
    m_data_in        = '0;
    m_keep_in        = '0;
    m_last_in        = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_id == CH_WD'(i)) begin
        sel_valid_insert = s_valid_insert[i];
        sel_valid_in     = s_valid_in[i];
        m_header_insert  = s_header_insert[i*DATA_WD +: DATA_WD];
        m_keep_insert    = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        m_data_in        = s_data_in[i*DATA_WD +: DATA_WD];
        m_keep_in        = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        m_last_in        = s_last_in[i];
      end
    end
  end

  // Valids and readies are gated by state, so reset (state forced to IDLE)
  // drops them asynchronously; only the granted channel can ever be acked.
  always_comb begin
    m_valid_insert = (state == HDR) && sel_valid_insert;
    m_valid_in     = (state == PAY) && sel_valid_in;
    s_ready_insert = '0;
    s_ready_in     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      s_ready_insert[i] = (state == HDR) && (grant_id == CH_WD'(i)) && m_ready_insert;
      s_ready_in[i]     = (state == PAY) && (grant_id == CH_WD'(i)) && m_ready_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      pkt_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_id <= arb_idx;
            state    <= HDR;
            busy     <= 1'b1;
          end
        end
        HDR: begin
          if (m_valid_insert && m_ready_insert) begin
            state <= PAY;
          end
        end
        PAY: begin
          if (m_valid_in && m_ready_in && m_last_in) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pkt_cnt <= pkt_cnt + 1'b1;
            if (grant_id == CH_WD'(NUM_CH - 1)) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= grant_id + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
module tb_axi_stream_header_arbiter;

  localparam int NUM_CH       = 4;
  localparam int DATA_WD      = 32;
  localparam int DATA_BYTE_WD = 4;
  localparam int CH_WD        = 2;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic [NUM_CH-1:0]              s_valid_insert = '0;
  logic [NUM_CH*DATA_WD-1:0]      s_header_insert = '0;
  logic [NUM_CH*DATA_BYTE_WD-1:0] s_keep_insert = '0;
  logic [NUM_CH-1:0]              s_ready_insert;
  logic [NUM_CH-1:0]              s_valid_in = '0;
  logic [NUM_CH*DATA_WD-1:0]      s_data_in = '0;
  logic [NUM_CH*DATA_BYTE_WD-1:0] s_keep_in = '0;
  logic [NUM_CH-1:0]              s_last_in = '0;
  logic [NUM_CH-1:0]              s_ready_in;
  logic                           m_valid_insert;
  logic [DATA_WD-1:0]             m_header_insert;
  logic [DATA_BYTE_WD-1:0]        m_keep_insert;
  logic                           m_ready_insert = 1'b1;
  logic                           m_valid_in;
  logic [DATA_WD-1:0]             m_data_in;
  logic [DATA_BYTE_WD-1:0]        m_keep_in;
  logic                           m_last_in;
  logic                           m_ready_in = 1'b1;
  logic [CH_WD-1:0]               grant_id;
  logic                           busy;
  logic [15:0]                    pkt_cnt;

  int checks = 0;
  int failures = 0;

  axi_stream_header_arbiter #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .NUM_CH       (NUM_CH),
    .CH_WD        (CH_WD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_valid_insert  (s_valid_insert),
    .s_header_insert (s_header_insert),
    .s_keep_insert   (s_keep_insert),
    .s_ready_insert  (s_ready_insert),
    .s_valid_in      (s_valid_in),
    .s_data_in       (s_data_in),
    .s_keep_in       (s_keep_in),
    .s_last_in       (s_last_in),
    .s_ready_in      (s_ready_in),
    .m_valid_insert  (m_valid_insert),
    .m_header_insert (m_header_insert),
    .m_keep_insert   (m_keep_insert),
    .m_ready_insert  (m_ready_insert),
    .m_valid_in      (m_valid_in),
    .m_data_in       (m_data_in),
    .m_keep_in       (m_keep_in),
    .m_last_in       (m_last_in),
    .m_ready_in      (m_ready_in),
    .grant_id        (grant_id),
    .busy            (busy),
    .pkt_cnt         (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_hdr(input int ch, input logic v, input logic [31:0] h, input logic [3:0] k);
    s_valid_insert[ch]          = v;
    s_header_insert[ch*32 +: 32] = h;
    s_keep_insert[ch*4 +: 4]     = k;
  endtask

  task automatic set_pay(input int ch, input logic v, input logic [31:0] d, input logic [3:0] k,
                         input logic l);
    s_valid_in[ch]         = v;
    s_data_in[ch*32 +: 32] = d;
    s_keep_in[ch*4 +: 4]   = k;
    s_last_in[ch]          = l;
  endtask

  initial begin
    // ---- Reset, with all four channels already requesting ----
    for (int c = 0; c < 4; c++) begin
      set_hdr(c, 1'b1, 32'h4844_0000 | c, 4'hF);
      set_pay(c, 1'b1, 32'hDA7A_0000 | c, 4'hF, 1'b1);
    end
    #12;
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt), 32'd0);
    chk("rst_rdy_ins", 32'(s_ready_insert), 32'd0);
    chk("rst_rdy_in", 32'(s_ready_in), 32'd0);
    chk("rst_mv_ins", 32'(m_valid_insert), 32'd0);
    chk("rst_mv_in", 32'(m_valid_in), 32'd0);
    #8 rst_n = 1'b1;

    // ---- Continuous requests: grants 0,1,2,3,0 with one IDLE cycle each ----
    for (int p = 0; p < 5; p++) begin
      tick();
      chk("rr_grant", 32'(grant_id), 32'(p % 4));
      chk("rr_busy_hdr", 32'(busy), 32'd1);
      chk("rr_mv_ins", 32'(m_valid_insert), 32'd1);
      chk("rr_hdr", m_header_insert, 32'h4844_0000 | (p % 4));
      chk("rr_rdy_ins", 32'(s_ready_insert), 32'd1 << (p % 4));
      tick();
      chk("rr_mv_in", 32'(m_valid_in), 32'd1);
      chk("rr_data", m_data_in, 32'hDA7A_0000 | (p % 4));
      chk("rr_rdy_in", 32'(s_ready_in), 32'd1 << (p % 4));
      chk("rr_mv_ins_pay", 32'(m_valid_insert), 32'd0);
      tick();
      chk("rr_busy_idle", 32'(busy), 32'd0);
      chk("rr_rdy_ins_idle", 32'(s_ready_insert), 32'd0);
      chk("rr_pkt", 32'(pkt_cnt), 32'(p + 1));
    end
    s_valid_insert = '0;
    s_valid_in     = '0;
    s_last_in      = '0;
    #3 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    chk("rst2_pkt", 32'(pkt_cnt), 32'd0);

    // ---- Channel 2, 3-beat packet ----
    set_hdr(2, 1'b1, 32'hA2A2_0002, 4'hF);
    set_pay(2, 1'b1, 32'hB0B0_0000, 4'hF, 1'b0);
    #1;
    chk("c2_early_stall", 32'(s_ready_in), 32'd0);
    tick();
    chk("c2_grant", 32'(grant_id), 32'd2);
    chk("c2_hdr", m_header_insert, 32'hA2A2_0002);
    chk("c2_rdy_ins", 32'(s_ready_insert), 32'b0100);
    tick();
    set_hdr(2, 1'b0, 32'h0, 4'h0);
    #1;
    chk("c2_b0", m_data_in, 32'hB0B0_0000);
    chk("c2_b0_last", 32'(m_last_in), 32'd0);
    chk("c2_rdy_in", 32'(s_ready_in), 32'b0100);
    tick();
    set_pay(2, 1'b1, 32'hB0B0_0001, 4'hF, 1'b0);
    #1;
    chk("c2_b1", m_data_in, 32'hB0B0_0001);
    chk("c2_b1_busy", 32'(busy), 32'd1);
    tick();
    set_pay(2, 1'b1, 32'hB0B0_0002, 4'h7, 1'b1);
    #1;
    chk("c2_b2", m_data_in, 32'hB0B0_0002);
    chk("c2_b2_keep", 32'(m_keep_in), 32'h7);
    chk("c2_b2_last", 32'(m_last_in), 32'd1);
    tick();
    set_pay(2, 1'b0, 32'h0, 4'h0, 1'b0);
    chk("c2_busy_end", 32'(busy), 32'd0);
    chk("c2_pkt", 32'(pkt_cnt), 32'd1);

    // ---- Pointer now 3: channels 0 and 3 request, 3 wins ----
    set_hdr(0, 1'b1, 32'h0000_0C00, 4'hF);
    set_hdr(3, 1'b1, 32'h0000_0C03, 4'hF);
    set_pay(0, 1'b1, 32'h1111_0000, 4'hF, 1'b1);
    set_pay(3, 1'b1, 32'h1111_0003, 4'hF, 1'b1);
    tick();
    chk("p3_grant", 32'(grant_id), 32'd3);
    chk("p3_rdy_ins", 32'(s_ready_insert), 32'b1000);
    tick();
    set_hdr(3, 1'b0, 32'h0, 4'h0);
    #1;
    chk("p3_rdy_in", 32'(s_ready_in), 32'b1000);
    tick();
    set_pay(3, 1'b0, 32'h0, 4'h0, 1'b0);
    chk("p3_pkt", 32'(pkt_cnt), 32'd2);
    tick();
    chk("p0_grant", 32'(grant_id), 32'd0);
    tick();
    set_hdr(0, 1'b0, 32'h0, 4'h0);
    tick();
    set_pay(0, 1'b0, 32'h0, 4'h0, 1'b0);
    chk("p0_pkt", 32'(pkt_cnt), 32'd3);

    // ---- Channel 1 packet moves the pointer to 2 ----
    set_hdr(1, 1'b1, 32'h0000_0D01, 4'hF);
    set_pay(1, 1'b1, 32'h2222_0001, 4'hF, 1'b1);
    tick();
    chk("m1_grant", 32'(grant_id), 32'd1);
    tick();
    set_hdr(1, 1'b0, 32'h0, 4'h0);
    tick();
    set_pay(1, 1'b0, 32'h0, 4'h0, 1'b0);
    chk("m1_pkt", 32'(pkt_cnt), 32'd4);

    // ---- Pointer 2: channels 1 and 3 request, 3 first, then 1 ----
    set_hdr(1, 1'b1, 32'h0000_0E01, 4'hF);
    set_hdr(3, 1'b1, 32'h0000_0E03, 4'hF);
    set_pay(3, 1'b1, 32'h3333_0003, 4'hF, 1'b1);
    set_pay(1, 1'b1, 32'h4444_0000, 4'hF, 1'b0);
    tick();
    chk("q3_grant", 32'(grant_id), 32'd3);
    chk("q3_rdy_ins", 32'(s_ready_insert), 32'b1000);
    tick();
    set_hdr(3, 1'b0, 32'h0, 4'h0);
    #1;
    chk("q3_rdy_ins_pay", 32'(s_ready_insert), 32'd0);
    chk("q3_rdy_in", 32'(s_ready_in), 32'b1000);
    tick();
    set_pay(3, 1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    chk("q3_idle_rdy_ins", 32'(s_ready_insert), 32'd0);
    chk("q3_pkt", 32'(pkt_cnt), 32'd5);
    tick();
    chk("q1_grant", 32'(grant_id), 32'd1);
    chk("q1_hdr", m_header_insert, 32'h0000_0E01);
    chk("q1_rdy_ins", 32'(s_ready_insert), 32'b0010);
    // Ready pattern 1,0,0,1 during PAY
    tick();
    set_hdr(1, 1'b0, 32'h0, 4'h0);
    m_ready_in = 1'b1;
    #1;
    chk("q1_b0", m_data_in, 32'h4444_0000);
    chk("q1_b0_rdy", 32'(s_ready_in), 32'b0010);
    tick();
    set_pay(1, 1'b1, 32'h4444_0001, 4'hF, 1'b1);
    m_ready_in = 1'b0;
    #1;
    chk("q1_b1_hold_a", m_data_in, 32'h4444_0001);
    chk("q1_b1_rdy_a", 32'(s_ready_in), 32'd0);
    chk("q1_b1_mv_a", 32'(m_valid_in), 32'd1);
    tick();
    chk("q1_b1_hold_b", m_data_in, 32'h4444_0001);
    chk("q1_b1_last_b", 32'(m_last_in), 32'd1);
    chk("q1_b1_busy_b", 32'(busy), 32'd1);
    chk("q1_b1_pkt_b", 32'(pkt_cnt), 32'd5);
    tick();
    m_ready_in = 1'b1;
    #1;
    chk("q1_b1_rdy_c", 32'(s_ready_in), 32'b0010);
    chk("q1_b1_busy_c", 32'(busy), 32'd1);
    tick();
    set_pay(1, 1'b0, 32'h0, 4'h0, 1'b0);
    chk("q1_busy_end", 32'(busy), 32'd0);
    chk("q1_pkt", 32'(pkt_cnt), 32'd6);

    // ---- Single-beat packet with partial keep on channel 0 ----
    set_hdr(0, 1'b1, 32'h0000_0F00, 4'hF);
    set_pay(0, 1'b1, 32'h5555_0000, 4'b0011, 1'b1);
    #1;
    chk("sb_idle", 32'(busy), 32'd0);
    tick();
    chk("sb_hdr_mv", 32'(m_valid_insert), 32'd1);
    chk("sb_grant", 32'(grant_id), 32'd0);
    chk("sb_hdr_mvin", 32'(m_valid_in), 32'd0);
    tick();
    set_hdr(0, 1'b0, 32'h0, 4'h0);
    #1;
    chk("sb_pay_mv", 32'(m_valid_in), 32'd1);
    chk("sb_keep", 32'(m_keep_in), 32'b0011);
    chk("sb_last", 32'(m_last_in), 32'd1);
    tick();
    set_pay(0, 1'b0, 32'h0, 4'h0, 1'b0);
    chk("sb_idle_end", 32'(busy), 32'd0);
    chk("sb_pkt", 32'(pkt_cnt), 32'd7);

    // ---- Asynchronous reset mid-PAY on channel 1 ----
    set_hdr(1, 1'b1, 32'h0000_0A01, 4'hF);
    set_pay(1, 1'b1, 32'h6666_0001, 4'hF, 1'b0);
    tick();
    chk("ar_grant", 32'(grant_id), 32'd1);
    tick();
    set_hdr(1, 1'b0, 32'h0, 4'h0);
    #1;
    chk("ar_pay_rdy", 32'(s_ready_in), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rdy_in", 32'(s_ready_in), 32'd0);
    chk("ar_mv_in", 32'(m_valid_in), 32'd0);
    chk("ar_rdy_ins", 32'(s_ready_insert), 32'd0);
    chk("ar_mv_ins", 32'(m_valid_insert), 32'd0);
    chk("ar_grant0", 32'(grant_id), 32'd0);
    chk("ar_pkt0", 32'(pkt_cnt), 32'd0);
    chk("ar_busy0", 32'(busy), 32'd0);
    set_pay(1, 1'b0, 32'h0, 4'h0, 1'b0);
    set_hdr(0, 1'b1, 32'h0000_0B00, 4'hF);
    #2 rst_n = 1'b1;
    tick();
    chk("ar_new_grant", 32'(grant_id), 32'd0);
    chk("ar_new_busy", 32'(busy), 32'd1);
    chk("ar_new_hdr", m_header_insert, 32'h0000_0B00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
